// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and the buffer entry type for the
//               instruction fetch buffer (instr_fetch_buf / fetch_fifo).
//               FETCH_XLEN is the default PC / instruction width and also
//               sizes the entry fields, so instr_fetch_buf is used with
//               XLEN == FETCH_XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    // addi x0, x0, 0 -- returned in place of a fetch that was never issued
    localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  filled;
        logic                  misalign;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Entry storage for the fetch buffer. Entries are allocated in
//               PC order at wr_ptr, filled in request order by memory
//               responses, and retired from rd_ptr. The fill target is the
//               oldest allocated entry that is still unfilled, which lets
//               pre-filled (never requested) entries sit between in-flight
//               ones without disturbing response ordering.
// Ports       : clk, rst (sync, active-low)
//               clear_i                     - drop every entry, pointers to 0
//               alloc_i / alloc_*_i         - allocate an entry at wr_ptr
//               fill_i / fill_data_i        - write response into fill target
//               deq_i                       - retire the head entry
//               head_o                      - entry at rd_ptr
//               alloc_cnt_o                 - number of allocated entries
//               unfilled_cnt_o              - allocated entries awaiting data
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear_i,
    input  logic                            alloc_i,
    input  logic [FETCH_XLEN-1:0]           alloc_pc_i,
    input  logic [FETCH_XLEN-1:0]           alloc_instr_i,
    input  logic                            alloc_filled_i,
    input  logic                            alloc_misalign_i,
    input  logic                            fill_i,
    input  logic [FETCH_XLEN-1:0]           fill_data_i,
    input  logic                            deq_i,
    output fetch_entry_t                    head_o,
    output logic [$clog2(DEPTH):0]          alloc_cnt_o,
    output logic [$clog2(DEPTH):0]          unfilled_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   entry_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  alloc_cnt_q;

    logic [PW-1:0]  w_fill_idx;
    logic [PW-1:0]  w_idx;
    logic           w_found;

    // Walk the allocated window from the head: count unfilled entries and
    // pick the oldest one as the fill target.
    always_comb begin
        unfilled_cnt_o = '0;
        w_fill_idx     = rd_ptr_q;
        w_found        = 1'b0;
        w_idx          = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < alloc_cnt_q) && !entry_q[w_idx].filled) begin
                unfilled_cnt_o = unfilled_cnt_o + CW'(1);
                if (!w_found) begin
                    w_found    = 1'b1;
                    w_fill_idx = w_idx;
                end
            end
        end
    end

    // alloc, fill and dequeue never target the same slot: wr_ptr is never
    // allocated, the fill target is unfilled and the dequeued head is filled.
    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            alloc_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            if (alloc_i) begin
                entry_q[wr_ptr_q] <= '{pc:       alloc_pc_i,
                                       instr:    alloc_instr_i,
                                       filled:   alloc_filled_i,
                                       misalign: alloc_misalign_i};
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (fill_i) begin
                entry_q[w_fill_idx].instr  <= fill_data_i;
                entry_q[w_fill_idx].filled <= 1'b1;
            end
            if (deq_i) begin
                entry_q[rd_ptr_q] <= '0;
                rd_ptr_q          <= rd_ptr_q + PW'(1);
            end
            alloc_cnt_q <= alloc_cnt_q + CW'(alloc_i) - CW'(deq_i);
        end
    end

    assign head_o      = entry_q[rd_ptr_q];
    assign alloc_cnt_o = alloc_cnt_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_buf
// Description : Fetch stage behind the PC register. Forwards accepted PCs to
//               instruction memory as in-order reads and buffers the returned
//               {pc, instr} pairs for decode behind a valid/ready interface.
//               A flush discards buffered entries and marks every in-flight
//               read to be dropped when it returns.
// Ports       : clk, rst (sync, active-low)
//               pc_in/pc_valid/pc_ready           - PC register handshake
//               flush                             - taken branch / jump
//               mem_req_valid/mem_req_ready/mem_addr
//               mem_rsp_valid/mem_rsp_data        - in-order read responses
//               instr_valid/instr_ready/instr_out/instr_pc - decode side
//               instr_misalign                    - FETCH_MISALIGN_CHECK_EN only
// Options     : FETCH_MISALIGN_CHECK_EN - misaligned PCs are accepted without a
//               memory read and return a pre-filled NOP flagged misaligned.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = FETCH_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic            flush,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_out,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            instr_misalign,
`endif
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CW1 = CW + 1;

    logic [CW-1:0]  drop_cnt_q;
    logic [CW-1:0]  drop_cnt_d;
    logic [CW-1:0]  w_alloc_cnt;
    logic [CW-1:0]  w_unfilled;
    fetch_entry_t   w_head;
    logic           w_credit;
    logic           w_misaligned;
    logic           w_accept;
    logic           w_fill;
    logic           w_deq;

    // Responses still owed to flushed fetches occupy slots as well, so they
    // count against the credit until they have been drained.
    assign w_credit = ({1'b0, w_alloc_cnt} + {1'b0, drop_cnt_q}) < CW1'(DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_misaligned = (pc_in[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // Misaligned PCs need no memory slot, so they do not wait on mem_req_ready.
    assign pc_ready      = rst & w_credit & ~flush & (mem_req_ready | w_misaligned);
    assign mem_req_valid = rst & pc_valid & w_credit & ~flush & ~w_misaligned;
    assign mem_addr      = pc_in;

    assign w_accept = pc_valid & pc_ready;
    assign w_fill   = mem_rsp_valid & ~flush & (drop_cnt_q == '0);
    assign w_deq    = instr_valid & instr_ready & ~flush;

    // Every response that arrives is either dropped or fills an entry; in the
    // flush cycle it is pre-flush data, so it always reduces the total owed.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = drop_cnt_q + w_unfilled - CW'(mem_rsp_valid);
        end else if (mem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk              (clk),
        .rst              (rst),
        .clear_i          (flush),
        .alloc_i          (w_accept),
        .alloc_pc_i       (pc_in),
        .alloc_instr_i    (w_misaligned ? NOP_INSTR : '0),
        .alloc_filled_i   (w_misaligned),
        .alloc_misalign_i (w_misaligned),
        .fill_i           (w_fill),
        .fill_data_i      (mem_rsp_data),
        .deq_i            (w_deq),
        .head_o           (w_head),
        .alloc_cnt_o      (w_alloc_cnt),
        .unfilled_cnt_o   (w_unfilled)
    );

    assign instr_valid = rst & w_head.filled;
    assign instr_out   = rst ? w_head.instr : '0;
    assign instr_pc    = rst ? w_head.pc    : '0;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign instr_misalign = rst & w_head.misalign;
`else
    logic w_unused_misalign;
    assign w_unused_misalign = w_head.misalign;
`endif

    a_drop_bound: assert property (@(posedge clk) disable iff (!rst)
        drop_cnt_q <= CW'(DEPTH));

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        mem_rsp_valid |-> ((drop_cnt_q != '0) || (w_unfilled != '0)));

endmodule : instr_fetch_buf
`default_nettype wire
